// File: rtl/inst_rom_ctrl_if.sv
// Fetch port and host loader link of the instruction ROM controller.
// slave = the ROM controller; master = the CPU fetch stage plus the host loader.
interface inst_rom_ctrl_if #(
    parameter int ADDR_W = 10
) ();
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              ld_start_i;
    logic [ADDR_W:0]   ld_len_i;
    logic              ld_valid_i;
    logic [7:0]        ld_byte_i;
    logic              ld_ready_o;
    logic              ld_busy_o;
    logic              ld_done_o;
    logic              cpu_hold_o;

    modport slave (
        input  rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
        output rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_hold_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
        input  rom_data_o, ld_ready_o, ld_busy_o, ld_done_o, cpu_hold_o
    );
endinterface

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM: zero-latency fetch port plus a byte-serial big-endian loader
// that holds the CPU and returns NOPs while it fills the memory.
module inst_rom_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    inst_rom_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    logic [31:0]     r_mem [DEPTH];
    state_t          r_state;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_wcnt;
    logic [1:0]      r_bcnt;
    logic [31:0]     r_asm;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_word_end;
    logic            w_last;
    logic [31:0]     w_word;
    logic [ADDR_W:0] w_len_clamp;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_accept    = bus.ld_valid_i && r_ready;
    assign w_word      = {r_asm[23:0], bus.ld_byte_i};
    assign w_word_end  = w_accept && (r_bcnt == 2'd3);
    assign w_last      = w_word_end && (r_wcnt == r_len - 1'b1);
    // Any length with the top bit set is at least the full depth.
    assign w_len_clamp = bus.ld_len_i[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.ld_len_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ld_start_i) begin
                        r_len  <= w_len_clamp;
                        r_wcnt <= '0;
                        r_bcnt <= '0;
                        r_asm  <= '0;
                        if (bus.ld_len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_asm  <= w_word;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_word_end) r_wcnt <= r_wcnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // No reset on the array: contents must survive a CPU/system reset.
    always_ff @(posedge clk) begin
        if (w_word_end) r_mem[r_wcnt[ADDR_W-1:0]] <= w_word;
    end

    always_comb begin
        w_rdata = '0;
        if (bus.rom_ce_i && !r_busy && (bus.rom_addr_i[31:ADDR_W+2] == '0))
            w_rdata = r_mem[bus.rom_addr_i[ADDR_W+1:2]];
    end

    assign w_unused       = &{1'b0, bus.rom_addr_i[1:0]};
    assign bus.rom_data_o = w_rdata;
    assign bus.ld_ready_o = r_ready;
    assign bus.ld_busy_o  = r_busy;
    assign bus.ld_done_o  = r_done;
    assign bus.cpu_hold_o = r_busy;
endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Directed bench for inst_rom_ctrl: reset, loads with and without host gaps,
// mid-load reset, zero-length and clamped full-depth loads.
module tb_inst_rom_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt;
    logic [7:0]  bq[$];
    logic [31:0] d;

    always #5 clk = ~clk;

    inst_rom_ctrl_if #(.ADDR_W(AW)) bus ();
    inst_rom_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic ce, output logic [31:0] q);
        bus.rom_ce_i   = ce;
        bus.rom_addr_i = a;
        #1;
        q = bus.rom_data_o;
    endtask

    task automatic start(input int len);
        bus.ld_len_i   = 11'(len);
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
    endtask

    // Streams bq; busy_cnt counts cycles in which busy was high.
    task automatic stream(input bit gaps);
        busy_cnt = 0;
        foreach (bq[i]) begin
            if (gaps) begin
                bus.ld_valid_i = 1'b0;
                if (bus.ld_busy_o) busy_cnt++;
                tick();
            end
            bus.ld_valid_i = 1'b1;
            bus.ld_byte_i  = bq[i];
            if (bus.ld_busy_o) busy_cnt++;
            tick();
        end
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.rom_ce_i = 1'b0; bus.rom_addr_i = '0; bus.ld_start_i = 1'b0;
        bus.ld_len_i = '0; bus.ld_valid_i = 1'b0; bus.ld_byte_i = '0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus.ld_ready_o, bus.ld_busy_o, bus.ld_done_o, bus.cpu_hold_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bus.ld_ready_o, bus.ld_busy_o, bus.ld_done_o, bus.cpu_hold_o});
        end
        fetch(32'h0000_1000, 1'b1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL fetch_out_of_range: got %h expected 00000000", d); end
        #12 rst = 1'b1;
        tick();
        checks++;
        if (bus.ld_busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_reset: got %b expected 0", bus.ld_busy_o); end
    endtask

    task automatic test_two_word();
        bq = '{8'h34, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h22, 8'h18, 8'h25};
        start(2);
        checks++;
        if ({bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o} !== 3'b111) begin
            errors++;
            $display("FAIL start_flags: got %b expected 111", {bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o});
        end
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL fetch_masked_in_load: got %h expected 00000000", d); end
        stream(1'b0);
        checks++;
        if (busy_cnt !== 8) begin errors++; $display("FAIL busy_cycles_2w: got %0d expected 8", busy_cnt); end
        checks++;
        if ({bus.ld_done_o, bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o} !== 4'b1000) begin
            errors++;
            $display("FAIL done_cycle: got %b expected 1000",
                     {bus.ld_done_o, bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o});
        end
        tick();
        checks++;
        if (bus.ld_done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", bus.ld_done_o); end
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'h3401000A) begin errors++; $display("FAIL read_w0: got %h expected 3401000a", d); end
        fetch(32'h4, 1'b1, d);
        checks++;
        if (d !== 32'h00221825) begin errors++; $display("FAIL read_w1: got %h expected 00221825", d); end
        fetch(32'h5, 1'b1, d);
        checks++;
        if (d !== 32'h00221825) begin errors++; $display("FAIL read_w1_unaligned: got %h expected 00221825", d); end
        fetch(32'h0, 1'b0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL read_ce_low: got %h expected 00000000", d); end
    endtask

    task automatic test_mid_load_reset();
        start(2);
        bq = '{8'h11, 8'h22};
        stream(1'b0);
        bus.ld_len_i   = '0;
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        checks++;
        if ({bus.ld_busy_o, bus.ld_done_o} !== 2'b10) begin
            errors++;
            $display("FAIL start_ignored_in_load: got %b expected 10", {bus.ld_busy_o, bus.ld_done_o});
        end
        bq = '{8'h33, 8'h44, 8'h55};
        stream(1'b0);
        rst = 1'b0;
        #2;
        checks++;
        if ({bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o} !== 3'b000) begin
            errors++;
            $display("FAIL midload_reset_flags: got %b expected 000", {bus.ld_busy_o, bus.ld_ready_o, bus.cpu_hold_o});
        end
        #2 rst = 1'b1;
        tick();
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'h11223344) begin errors++; $display("FAIL w0_retained: got %h expected 11223344", d); end
        fetch(32'h4, 1'b1, d);
        checks++;
        if (d !== 32'h00221825) begin errors++; $display("FAIL w1_unchanged: got %h expected 00221825", d); end
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        start(1);
        stream(1'b0);
        checks++;
        if (busy_cnt !== 4 || bus.ld_done_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_1w: got busy=%0d done=%b expected busy=4 done=1", busy_cnt, bus.ld_done_o);
        end
        tick();
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL restart_w0: got %h expected deadbeef", d); end
        fetch(32'h4, 1'b1, d);
        checks++;
        if (d !== 32'h00221825) begin errors++; $display("FAIL restart_w1: got %h expected 00221825", d); end
    endtask

    task automatic test_host_gaps();
        bq = '{8'h34, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h22, 8'h18, 8'h25};
        start(2);
        stream(1'b1);
        checks++;
        if (busy_cnt !== 16) begin errors++; $display("FAIL busy_cycles_gaps: got %0d expected 16", busy_cnt); end
        checks++;
        if (bus.ld_done_o !== 1'b1) begin errors++; $display("FAIL done_gaps: got %b expected 1", bus.ld_done_o); end
        tick();
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'h3401000A) begin errors++; $display("FAIL gaps_w0: got %h expected 3401000a", d); end
        fetch(32'h4, 1'b1, d);
        checks++;
        if (d !== 32'h00221825) begin errors++; $display("FAIL gaps_w1: got %h expected 00221825", d); end
    endtask

    task automatic test_zero_len();
        start(0);
        checks++;
        if ({bus.ld_done_o, bus.ld_busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL zero_len_done: got %b expected 10", {bus.ld_done_o, bus.ld_busy_o});
        end
        tick();
        checks++;
        if ({bus.ld_done_o, bus.ld_busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL zero_len_idle: got %b expected 00", {bus.ld_done_o, bus.ld_busy_o});
        end
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'h3401000A) begin errors++; $display("FAIL zero_len_nowrite: got %h expected 3401000a", d); end
    endtask

    task automatic test_clamp();
        bq.delete();
        for (int w = 0; w < 1024; w++) begin
            bq.push_back(8'hA5);
            bq.push_back(8'h00);
            bq.push_back(8'(w >> 8));
            bq.push_back(8'(w));
        end
        start(2047);
        stream(1'b0);
        checks++;
        if (busy_cnt !== 4096) begin errors++; $display("FAIL clamp_busy: got %0d expected 4096", busy_cnt); end
        checks++;
        if (bus.ld_done_o !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b expected 1", bus.ld_done_o); end
        tick();
        fetch(32'hFFC, 1'b1, d);
        checks++;
        if (d !== 32'hA50003FF) begin errors++; $display("FAIL clamp_last: got %h expected a50003ff", d); end
        fetch(32'h800, 1'b1, d);
        checks++;
        if (d !== 32'hA5000200) begin errors++; $display("FAIL clamp_mid: got %h expected a5000200", d); end
        fetch(32'h0, 1'b1, d);
        checks++;
        if (d !== 32'hA5000000) begin errors++; $display("FAIL clamp_first: got %h expected a5000000", d); end
        fetch(32'h1000, 1'b1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clamp_oor: got %h expected 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_mid_load_reset();
        test_host_gaps();
        test_zero_len();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_rom_ctrl.md
# inst_rom_ctrl

Instruction-memory responder for the CPU fetch port: it answers `rom_ce`/`rom_addr` requests with the 32-bit instruction word on `rom_data` in the same cycle, as the IF/ID register expects. It also contains a byte-serial loader FSM that fills the memory from a host stream (valid/ready), big-endian, one word per four bytes. While loading it holds the CPU and returns NOPs. It sits beside the CPU top, between the host loader link and the fetch port.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W words of 32 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_ce_i`  in  1  fetch enable from the CPU.
- `rom_addr_i`  in  32  fetch byte address from the CPU pc.
- `rom_data_o`  out  32  instruction word to the CPU (combinational).
- `ld_start_i`  in  1  single-cycle pulse that begins a load at word 0.
- `ld_len_i`  in  ADDR_W+1  number of words to load; sampled with `ld_start_i`.
- `ld_valid_i`  in  1  host byte valid.
- `ld_byte_i`  in  8  host byte.
- `ld_ready_o`  out  1  loader accepts a byte.
- `ld_busy_o`  out  1  load in progress.
- `ld_done_o`  out  1  one-cycle pulse when a load completes.
- `cpu_hold_o`  out  1  drives CPU reset/hold; equal to `ld_busy_o`.

## Operation
- **Fetch read:** `rom_data_o` = mem[`rom_addr_i[ADDR_W+1:2]`] when `rom_ce_i`=1, `ld_busy_o`=0, and `rom_addr_i[31:ADDR_W+2]`=0. In every other case it is 0x00000000 (a NOP). Address bits [1:0] are ignored.
- **Memory:** 2^ADDR_W×32 array. It is not cleared by reset, and its contents survive reset.
- **FSM states:**
  - IDLE → LOAD on `ld_start_i`=1 when `ld_len_i`≠0.
  - IDLE → DONE on `ld_start_i`=1 when `ld_len_i`=0.
  - LOAD → DONE when the final byte of the final word is accepted.
  - DONE → IDLE unconditionally.
- **Length latch:** `len` is latched at start, clamped to 2^ADDR_W if larger. The word counter `wcnt` and byte counter `bcnt` are cleared at start.
- **Byte accept:** occurs when `ld_valid_i` && `ld_ready_o`. The byte is shifted into a 32-bit assembly register, first byte in bits [31:24].
  - `bcnt` increments 0..3.
  - On the accept with `bcnt`=3, the assembled word is written to mem[`wcnt`], `wcnt` increments, and `bcnt` wraps to 0.
- **Outputs by state:**
  - `ld_ready_o`=1 and `ld_busy_o`=1 only in LOAD.
  - `ld_done_o`=1 only in DONE.
- **Ignored inputs:** `ld_start_i` is ignored in LOAD and DONE. `ld_valid_i` is ignored outside LOAD.
- **Reset during a load:** reset mid-load returns to IDLE. Words already written stay written, and a partial word is discarded.

## Timing
- **Reset values:** state IDLE, `ld_ready_o`=0, `ld_busy_o`=0, `ld_done_o`=0, `cpu_hold_o`=0, counters and assembly register 0. `rom_data_o` follows the combinational rule above.
- **Fetch latency:** zero cycles; `rom_data_o` is valid in the same cycle as `rom_addr_i`.
- **Start:** `ld_start_i` high at edge N puts `ld_busy_o`, `ld_ready_o` and `cpu_hold_o` high from N+1.
- **Byte rate:** one byte per cycle maximum; a full word takes at least 4 cycles.
- **Write visibility:** a word written at edge E is readable from the cycle after E.
- **Completion:** final byte accepted at edge E puts DONE in cycle E+1 (`ld_done_o`=1, `busy`/`ready`/`hold`=0) and IDLE in cycle E+2.
- **Zero-length load:** start at edge N gives DONE in cycle N+1 and no writes.
- **Minimum load time:** N words take 4N cycles plus 1 DONE cycle.

## Test plan
- **Reset and out-of-range fetch:** assert `rst`=0 mid-cycle, then release. All outputs are 0. Fetch at 0x0000_1000 with `ADDR_W`=10 returns 0x00000000.
- **Two-word load and readback:** `ld_len`=2, stream 0x34,0x01,0x00,0x0A,0x00,0x22,0x18,0x25 with valid held. The sequence is:
  1. Busy for 8 cycles.
  2. `ld_done_o` pulses for one cycle.
  3. Fetch 0x0 returns 0x3401000A; fetch 0x4 and fetch 0x5 each return 0x00221825.
- **Host gaps:** same load with `ld_valid_i` toggled 1/0. Identical memory contents result, and busy lasts 16 cycles.
- **Hold and masking:** during a load `cpu_hold_o`=1 and a fetch with `rom_ce_i`=1 returns 0. With `rom_ce_i`=0 after the load, the fetch returns 0.
- **Mid-load reset and restart:** reset after 5 bytes of a 2-word load.
  - Word 0 is retained and word 1 is unchanged.
  - A new `ld_start_i` restarts at word 0.
  - `ld_start_i` pulsed during LOAD has no effect.
- **Boundary lengths:**
  - `ld_len`=0 gives `ld_done_o` the cycle after start and no writes.
  - `ld_len`=2047 clamps to 1024 words; the last word lands at 0xFFC and done follows the 4096th byte.
